// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared FSM encoding and default parameters for the data RAM
package data_ram_pkg;
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 16;
  localparam int DEPTH_DEF     = 256;
  localparam int CLEAR_VAL_DEF = 0;
endpackage

// File: rtl/ram_array.sv
// ram_array: byte-enabled write port plus read-before-write synchronous read port
module ram_array
  import data_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = 8
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  // storage has no reset; a read samples the pre-edge word, the owner merges any same-edge write
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++)
      if (we_i && be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_ram_sync.sv
// data_ram_sync: single-port data RAM with post-reset clear, byte writes and write-first reads
module data_ram_sync
  import data_ram_pkg::*;
#(
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = DATA_W'(CLEAR_VAL_DEF)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   DataAddress,
  input  logic                ReadMem,
  input  logic                WriteMem,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic [DATA_W-1:0]   DataIn,
  output logic [DATA_W-1:0]   DataOut,
  output logic                ReadValid,
  output logic                Busy,
  output logic                AddrError
);
  localparam int NB = DATA_W / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              rv_q, rv_d, err_q, err_d, fwd_q, fwd_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] din_q, din_d, hold_q;
  logic              idle, in_range, we;
  logic [NB-1:0]     wbe;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata, rdata, merged;
  // next state, clear sequencing, memory port muxing and request qualification
  always_comb begin
    idle     = state_q == IDLE;
    in_range = 64'(DataAddress) < 64'(DEPTH);
    state_d  = state_q;
    ptr_d    = ptr_q;
    if (!idle) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
    end
    we    = !idle || (WriteMem && in_range);
    wbe   = idle ? ByteEn : '1;
    waddr = idle ? DataAddress[AW-1:0] : ptr_q;
    wdata = idle ? DataIn : CLEAR_VAL;
    rv_d  = idle && ReadMem;
    err_d = idle && !in_range && (ReadMem || (WriteMem && |ByteEn));
    fwd_d = rv_d && WriteMem && in_range;
    be_d  = ByteEn;
    din_d = DataIn;
  end
  ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .be_i    (wbe),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (rv_d),
    .raddr_i (DataAddress[AW-1:0]),
    .rdata_o (rdata)
  );
  // overlay the bytes written on the read edge so a same-address read sees the new word
  always_comb begin
    merged = rdata;
    for (int b = 0; b < NB; b++)
      merged[8*b +: 8] = fwd_q && be_q[b] ? din_q[8*b +: 8] : rdata[8*b +: 8];
  end
  assign DataOut   = rv_q ? (err_q ? '0 : merged) : hold_q;
  assign ReadValid = rv_q;
  assign AddrError = err_q;
  assign Busy      = state_q == CLEAR;
  // state, clear pointer, read pipeline and held output word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      fwd_q   <= 1'b0;
      be_q    <= '0;
      din_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      fwd_q   <= fwd_d;
      be_q    <= be_d;
      din_q   <= din_d;
      hold_q  <= DataOut;
    end
  end
endmodule

// File: tb/tb_data_ram_sync.sv
// tb_data_ram_sync: directed vector bench for data_ram_sync
module tb_data_ram_sync;
  logic        clk, reset_n, ReadMem, WriteMem, ReadValid, Busy, AddrError;
  logic [15:0] DataAddress, DataIn, DataOut;
  logic [1:0]  ByteEn;
  int          passed = 0, total = 0;
  typedef struct {
    logic        rd, wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] din;
    logic        rv, err;
    logic [15:0] dout;
  } vec_t;
  vec_t v [22];
  data_ram_sync dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .ByteEn      (ByteEn),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .ReadValid   (ReadValid),
    .Busy        (Busy),
    .AddrError   (AddrError)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic count_busy(input string tag);
    int n = 0;
    int bad = 0;
    while (Busy && n < 1000) begin
      if (ReadValid || AddrError) bad++;
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, n, 256);
    check({tag, "_busy_quiet"}, bad, 0);
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
    ReadMem = rd; WriteMem = wr; DataAddress = a; ByteEn = be; DataIn = d;
  endtask
  task automatic step_read(input logic [15:0] a, input logic [15:0] exp, input string nm);
    drive(1, 0, a, 2'b00, 16'h0);
    @(posedge clk); @(negedge clk);
    check({nm, "_rv"}, ReadValid, 1);
    check({nm, "_dout"}, DataOut, exp);
    drive(0, 0, 16'h0, 2'b00, 16'h0);
  endtask
  initial begin
    v[0]  = '{0, 1, 16'h0010, 2'b11, 16'hBEEF, 0, 0, 16'h0000};
    v[1]  = '{1, 0, 16'h0010, 2'b00, 16'h0000, 1, 0, 16'hBEEF};
    v[2]  = '{0, 1, 16'h0010, 2'b01, 16'h1234, 0, 0, 16'hBEEF};
    v[3]  = '{1, 0, 16'h0010, 2'b00, 16'h0000, 1, 0, 16'hBE34};
    v[4]  = '{1, 1, 16'h0020, 2'b11, 16'hA5A5, 1, 0, 16'hA5A5};
    v[5]  = '{1, 0, 16'h0100, 2'b00, 16'h0000, 1, 1, 16'h0000};
    v[6]  = '{0, 1, 16'h0100, 2'b11, 16'hFFFF, 0, 1, 16'h0000};
    v[7]  = '{1, 0, 16'h0000, 2'b00, 16'h0000, 1, 0, 16'h0000};
    v[8]  = '{0, 1, 16'h0010, 2'b00, 16'h0000, 0, 0, 16'h0000};
    v[9]  = '{1, 0, 16'h0010, 2'b00, 16'h0000, 1, 0, 16'hBE34};
    v[10] = '{0, 1, 16'h0030, 2'b10, 16'hCAFE, 0, 0, 16'hBE34};
    v[11] = '{1, 0, 16'h0030, 2'b00, 16'h0000, 1, 0, 16'hCA00};
    v[12] = '{0, 1, 16'h0010, 2'b11, 16'h7777, 0, 0, 16'hCA00};
    v[13] = '{1, 0, 16'h0010, 2'b00, 16'h0000, 1, 0, 16'h7777};
    v[14] = '{1, 0, 16'h0020, 2'b00, 16'h0000, 1, 0, 16'hA5A5};
    v[15] = '{1, 0, 16'h0030, 2'b00, 16'h0000, 1, 0, 16'hCA00};
    v[16] = '{0, 0, 16'h0000, 2'b00, 16'h0000, 0, 0, 16'hCA00};
    v[17] = '{1, 1, 16'h0030, 2'b01, 16'h0011, 1, 0, 16'hCA11};
    v[18] = '{1, 0, 16'h00FF, 2'b00, 16'h0000, 1, 0, 16'h0000};
    v[19] = '{0, 1, 16'h00FF, 2'b11, 16'h5A5A, 0, 0, 16'h0000};
    v[20] = '{1, 0, 16'h00FF, 2'b00, 16'h0000, 1, 0, 16'h5A5A};
    v[21] = '{1, 1, 16'h0100, 2'b11, 16'h1111, 1, 1, 16'h0000};
    reset_n = 1'b1;
    drive(0, 0, 16'h0, 2'b00, 16'h0);
    #1 reset_n = 1'b0;
    #2;
    check("rst_dout", DataOut, 0);
    check("rst_rv", ReadValid, 0);
    check("rst_err", AddrError, 0);
    check("rst_busy", Busy, 1);
    @(negedge clk); @(negedge clk);
    drive(1, 0, 16'h0005, 2'b00, 16'h0);
    reset_n = 1'b1;
    count_busy("init");
    check("fall_no_rv", ReadValid, 0);
    @(posedge clk); @(negedge clk);
    check("first_rv", ReadValid, 1);
    check("first_dout", DataOut, 16'h0000);
    check("first_err", AddrError, 0);
    for (int i = 0; i < 22; i++) begin
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].be, v[i].din);
      @(posedge clk); @(negedge clk);
      check($sformatf("v%0d_rv", i), ReadValid, v[i].rv);
      check($sformatf("v%0d_err", i), AddrError, v[i].err);
      check($sformatf("v%0d_dout", i), DataOut, v[i].dout);
    end
    drive(1, 0, 16'h00FF, 2'b00, 16'h0);
    @(posedge clk);
    #2;
    check("pre_rst_dout", DataOut, 16'h5A5A);
    reset_n = 1'b0;
    #1;
    check("async_dout", DataOut, 0);
    check("async_rv", ReadValid, 0);
    check("async_busy", Busy, 1);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy("access");
    @(posedge clk); @(negedge clk);
    check("reclr_rv", ReadValid, 1);
    check("reclr_dout", DataOut, 16'h0000);
    drive(0, 0, 16'h0, 2'b00, 16'h0);
    step_read(16'h0010, 16'h0000, "reclr_10");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check("mid_busy_pre", Busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", Busy, 1);
    check("mid_rv", ReadValid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy("midclr");
    step_read(16'h00FF, 16'h0000, "final_ff");
    step_read(16'h0020, 16'h0000, "final_20");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
